// File: rtl/gen_fifo_reader.sv
// Read-side controller for the generator FIFO: fetches samples into a two-entry
// buffer and presents them on a valid/ready stream with a delivered-sample counter.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef RESET_VALUE
`define RESET_VALUE 16'hA5A5
`endif

module gen_fifo_reader #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enh,
  input  logic                  clrh,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic                  busy,
  output logic                  drained
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(`RESET_VALUE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic [2:0]            level;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf0;
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE);

  // Occupancy after this cycle's capture and pop; a read may only be issued
  // when the sample it returns is guaranteed a free buffer slot.
  assign level   = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_rd = (state == RUN) && !fifo_empty && !clrh && !rst && (level < 3'd2);

  always_ff @(posedge clk) begin
    if (rst || clrh) begin
      state      <= IDLE;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      buf0       <= RST_DATA;
      buf1       <= RST_DATA;
      sample_cnt <= '0;
      drained    <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      occ      <= level[1:0];
      drained  <= 1'b0;

      if (pop)
        sample_cnt <= sample_cnt + CNT_WIDTH'(1);

      // buf0 is the head; a capture lands at whatever slot is the tail after the pop
      if (pop && inflight) begin
        if (occ == 2'd2) begin
          buf0 <= buf1;
          buf1 <= fifo_rdata;
        end else begin
          buf0 <= fifo_rdata;
        end
      end else if (pop) begin
        buf0 <= buf1;
      end else if (inflight) begin
        if (occ == 2'd0)
          buf0 <= fifo_rdata;
        else
          buf1 <= fifo_rdata;
      end

      case (state)
        IDLE:  if (enh) state <= RUN;
        RUN:   if (!enh) state <= DRAIN;
        DRAIN: begin
          if (occ == 2'd0 && !inflight) begin
            state   <= IDLE;
            drained <= 1'b1;
          end else if (enh) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_fifo_reader.sv
// Self-checking bench for gen_fifo_reader: a queue-based FIFO model feeds the DUT
// and delivered samples are compared against FIFO order and the protocol rules.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef RESET_VALUE
`define RESET_VALUE 16'hA5A5
`endif

module tb_gen_fifo_reader;

  localparam int DW = `DATA_WIDTH;
  localparam int CW = 16;
  localparam logic [DW-1:0] RV = DW'(`RESET_VALUE);

  logic          clk = 1'b0;
  logic          rst, enh, clrh, fifo_empty, m_ready;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_rd, m_valid, busy, drained;
  logic [DW-1:0] m_data;
  logic [CW-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] got_q[$];
  int            rd_pulses, rd_empty_viol, hold_viol, drained_pulses, over_viol, iss, dlv;
  logic          held;
  logic [DW-1:0] held_data;
  logic [CW-1:0] cnt_now, cnt_next;

  always #5 clk = ~clk;

  gen_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enh(enh), .clrh(clrh),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .sample_cnt(sample_cnt), .busy(busy), .drained(drained)
  );

  // FIFO model: read data appears the cycle after the strobe
  always @(posedge clk)
    if (fifo_rd === 1'b1 && fq.size() > 0) fifo_rdata <= fq.pop_front();

  // One clock of stimulus; observes outputs mid-cycle and logs what the consumer sees
  task automatic step(input logic en, input logic rdy, input logic clr, input logic rs, input logic fe);
    @(negedge clk);
    cnt_now    = cnt_next;
    enh        = en;
    m_ready    = rdy;
    clrh       = clr;
    rst        = rs;
    fifo_empty = fe || (fq.size() == 0);
    #1;
    if (fifo_rd === 1'b1) begin
      rd_pulses++;
      iss++;
      if (fifo_empty) rd_empty_viol++;
    end
    if (drained === 1'b1) drained_pulses++;
    if (held && (m_valid !== 1'b1 || m_data !== held_data)) hold_viol++;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      got_q.push_back(m_data);
      dlv++;
      cnt_next = cnt_next + CW'(1);
    end
    held      = (m_valid === 1'b1) && (m_ready !== 1'b1);
    held_data = m_data;
    if (clr || rs) begin
      held     = 1'b0;
      iss      = 0;
      dlv      = 0;
      cnt_next = '0;
    end
    if (iss - dlv > 2) over_viol++;
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    fq.delete();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    got_q.delete();
    rd_pulses = 0; rd_empty_viol = 0; hold_viol = 0; drained_pulses = 0; over_viol = 0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo_rd: got %b, expected 0", fifo_rd); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b, expected 0", m_valid); end
    checks++; if (m_data !== RV) begin errors++; $display("[TB] FAIL reset_m_data: got %h, expected %h", m_data, RV); end
    checks++; if (sample_cnt !== '0) begin errors++; $display("[TB] FAIL reset_sample_cnt: got %0d, expected 0", sample_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (drained !== 1'b0) begin errors++; $display("[TB] FAIL reset_drained: got %b, expected 0", drained); end
  endtask

  task automatic test_basic_order();
    logic [DW-1:0] exp[$];
    int first, last;
    flush();
    exp = '{DW'('h11), DW'('h22), DW'('h33)};
    foreach (exp[k]) fq.push_back(exp[k]);
    first = -1; last = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (m_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++; if (first != 3) begin errors++; $display("[TB] FAIL basic_latency: first valid cycle %0d, expected 3", first); end
    checks++; if (last != 5) begin errors++; $display("[TB] FAIL basic_consecutive: last valid cycle %0d, expected 5", last); end
    checks++; if (got_q.size() != 3) begin errors++; $display("[TB] FAIL basic_count: got %0d samples, expected 3", got_q.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_q[k] !== exp[k]) begin errors++; $display("[TB] FAIL basic_data%0d: got %h, expected %h", k, got_q[k], exp[k]); end
    end
    checks++; if (sample_cnt !== CW'(3)) begin errors++; $display("[TB] FAIL basic_cnt: got %0d, expected 3", sample_cnt); end
  endtask

  task automatic test_backpressure();
    int bad;
    flush();
    for (int v = 1; v <= 8; v++) fq.push_back(DW'(v));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_pulses != 2) begin errors++; $display("[TB] FAIL bp_reads: got %0d reads, expected 2", rd_pulses); end
    checks++; if (m_valid !== 1'b1 || m_data !== DW'(1)) begin errors++; $display("[TB] FAIL bp_head: got valid=%b data=%h, expected valid=1 data=0001", m_valid, m_data); end
    checks++; if (hold_viol != 0) begin errors++; $display("[TB] FAIL bp_hold: %0d unstable cycles, expected 0", hold_viol); end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < 8; k++) if (got_q[k] !== DW'(k + 1)) bad++;
    checks++; if (got_q.size() != 8 || bad != 0) begin errors++; $display("[TB] FAIL bp_order: got %0d samples with %0d wrong, expected 8 with 0 wrong", got_q.size(), bad); end
    checks++; if (over_viol != 0) begin errors++; $display("[TB] FAIL bp_outstanding: %0d cycles above 2, expected 0", over_viol); end
  endtask

  task automatic test_empty_toggle();
    logic [DW-1:0] exp[$];
    int bad;
    flush();
    for (int k = 0; k < 16; k++) begin exp.push_back(DW'($urandom)); fq.push_back(exp[k]); end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'(((i / 2) % 2) == 1));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_empty_viol != 0) begin errors++; $display("[TB] FAIL empty_rd: %0d reads while empty, expected 0", rd_empty_viol); end
    bad = 0;
    for (int k = 0; k < 16; k++) if (got_q[k] !== exp[k]) bad++;
    checks++; if (got_q.size() != 16 || bad != 0) begin errors++; $display("[TB] FAIL empty_order: got %0d samples with %0d wrong, expected 16 with 0 wrong", got_q.size(), bad); end
  endtask

  task automatic test_drain();
    logic busy_at_drain;
    int bad;
    flush();
    for (int k = 0; k < 5; k++) fq.push_back(DW'('h50 + k));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    busy_at_drain = 1'bx;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (drained === 1'b1) busy_at_drain = busy;
    end
    checks++; if (got_q.size() != 3) begin errors++; $display("[TB] FAIL drain_count: got %0d samples, expected 3", got_q.size()); end
    checks++; if (got_q.size() != rd_pulses) begin errors++; $display("[TB] FAIL drain_lost: delivered %0d, reads issued %0d", got_q.size(), rd_pulses); end
    bad = 0;
    for (int k = 0; k < 3; k++) if (got_q[k] !== DW'('h50 + k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL drain_order: %0d wrong samples, expected 0", bad); end
    checks++; if (drained_pulses != 1) begin errors++; $display("[TB] FAIL drain_pulse: drained high %0d cycles, expected 1", drained_pulses); end
    checks++; if (busy_at_drain !== 1'b0) begin errors++; $display("[TB] FAIL drain_busy: busy=%b at drained pulse, expected 0", busy_at_drain); end
  endtask

  task automatic test_clear();
    logic [DW-1:0] exp[$];
    logic [DW-1:0] nxt;
    int pre, bad;
    flush();
    for (int k = 0; k < 10; k++) begin exp.push_back(DW'('h60 + k)); fq.push_back(exp[k]); end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pre = got_q.size();
    nxt = fq[0];
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_valid: got %b, expected 0", m_valid); end
    checks++; if (sample_cnt !== '0) begin errors++; $display("[TB] FAIL clr_cnt: got %0d, expected 0", sample_cnt); end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (pre != 4) begin errors++; $display("[TB] FAIL clr_pre_count: got %0d pre-clear samples, expected 4", pre); end
    bad = 0;
    for (int k = 0; k < pre; k++) if (got_q[k] !== exp[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL clr_pre_order: %0d wrong samples, expected 0", bad); end
    checks++; if (got_q[pre] !== nxt) begin errors++; $display("[TB] FAIL clr_restart: got %h, expected %h", got_q[pre], nxt); end
    checks++; if (drained_pulses != 0) begin errors++; $display("[TB] FAIL clr_drained: drained high %0d cycles, expected 0", drained_pulses); end
    checks++; if (sample_cnt !== cnt_now) begin errors++; $display("[TB] FAIL clr_recount: got %0d, expected %0d", sample_cnt, cnt_now); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp[$];
    int bad;
    flush();
    for (int k = 0; k < 40; k++) begin exp.push_back(DW'($urandom)); fq.push_back(exp[k]); end
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 2) == 0));
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < 40; k++) if (got_q[k] !== exp[k]) bad++;
    checks++; if (got_q.size() != 40 || bad != 0) begin errors++; $display("[TB] FAIL rand_order: got %0d samples with %0d wrong, expected 40 with 0 wrong", got_q.size(), bad); end
    checks++; if (rd_empty_viol != 0) begin errors++; $display("[TB] FAIL rand_rd_empty: %0d reads while empty, expected 0", rd_empty_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("[TB] FAIL rand_hold: %0d unstable cycles, expected 0", hold_viol); end
    checks++; if (over_viol != 0) begin errors++; $display("[TB] FAIL rand_outstanding: %0d cycles above 2, expected 0", over_viol); end
    checks++; if (sample_cnt !== CW'(40)) begin errors++; $display("[TB] FAIL rand_cnt: got %0d, expected 40", sample_cnt); end
  endtask

  task automatic test_wrap_and_rst();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v, d, e, nxt;
    int delivered, cycles, data_bad;
    flush();
    delivered = 0; cycles = 0; data_bad = 0;
    while (delivered < 65537 && cycles < 65700) begin
      if (fq.size() < 4) begin v = DW'($urandom); fq.push_back(v); exp_q.push_back(v); end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycles++;
      while (got_q.size() > 0) begin
        d = got_q.pop_front();
        e = exp_q.pop_front();
        if (d !== e) data_bad++;
        delivered++;
      end
    end
    checks++; if (delivered != 65537) begin errors++; $display("[TB] FAIL wrap_budget: delivered %0d, expected 65537", delivered); end
    checks++; if (cycles != 65540) begin errors++; $display("[TB] FAIL wrap_throughput: took %0d cycles, expected 65540", cycles); end
    checks++; if (data_bad != 0) begin errors++; $display("[TB] FAIL wrap_data: %0d wrong samples, expected 0", data_bad); end
    fq.push_back(DW'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (sample_cnt !== CW'(1)) begin errors++; $display("[TB] FAIL wrap_cnt: got %0d, expected 1", sample_cnt); end
    fq.push_back(DW'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    nxt = fq[0];
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL rst_fifo_rd: got %b, expected 0", fifo_rd); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_valid: got %b, expected 0", m_valid); end
    checks++; if (m_data !== RV) begin errors++; $display("[TB] FAIL rst_m_data: got %h, expected %h", m_data, RV); end
    checks++; if (sample_cnt !== '0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d, expected 0", sample_cnt); end
    checks++; if (busy !== 1'b0 || drained !== 1'b0) begin errors++; $display("[TB] FAIL rst_status: got busy=%b drained=%b, expected 0 0", busy, drained); end
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (fq.size() < 4) fq.push_back(DW'($urandom));
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (got_q.size() == 0 || got_q[0] !== nxt) begin errors++; $display("[TB] FAIL rst_restart: got %h (%0d samples), expected %h", got_q.size() > 0 ? got_q[0] : RV, got_q.size(), nxt); end
  endtask

  initial begin
    rst = 1'b1; enh = 1'b0; clrh = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    held = 1'b0; held_data = '0; cnt_now = '0; cnt_next = '0;
    rd_pulses = 0; rd_empty_viol = 0; hold_viol = 0; drained_pulses = 0; over_viol = 0;
    iss = 0; dlv = 0;
    test_reset();
    test_basic_order();
    test_backpressure();
    test_empty_toggle();
    test_drain();
    test_clear();
    test_random();
    test_wrap_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
